// File: rtl/dpram_pkg.sv
// dpram_pkg: shared declarations for the single-clock true dual-port RAM.
//   - default geometry (NUM_LANES, DEPTH) for the standard 32 x 8 scratch buffer
//   - FSM state type for the clear engine
//   - lane merge helper used by both write ports
package dpram_pkg;

   localparam int ADDR_WIDTH_DEF = 5;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int LANE_WIDTH_DEF = 8;
   localparam int NUM_LANES      = DATA_WIDTH_DEF / LANE_WIDTH_DEF;
   localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

   // Widest word the merge helper handles; callers cast in and out.
   localparam int MERGE_W = 64;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Bits set in bit_mask take new_word, the rest keep old_word.
   function automatic logic [MERGE_W-1:0] merge_word(input logic [MERGE_W-1:0] old_word,
                                                      input logic [MERGE_W-1:0] new_word,
                                                      input logic [MERGE_W-1:0] bit_mask);
      return (old_word & ~bit_mask) | (new_word & bit_mask);
   endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: read-data / read-valid delay line for one RAM port.
//   clk, rst      clock, asynchronous active-low reset
//   vld_p0        a read result is presented this cycle
//   data_p0       word captured with vld_p0
//   vld_out       valid strobe, RD_LATENCY cycles after the access edge
//   data_out      last valid word; holds between strobes
module dpram_rd_pipe
   import dpram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int RD_LATENCY = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_p0,
   input  logic [DATA_WIDTH-1:0] data_p0,
   output logic                  vld_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;

   // stage p0 -> p1: capture at the access edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) data_p1 <= data_p0;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  vld_p2;
         logic [DATA_WIDTH-1:0] data_p2;

         // stage p1 -> p2: optional output register
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_p2  <= 1'b0;
               data_p2 <= '0;
            end else begin
               vld_p2 <= vld_p1;
               if (vld_p1) data_p2 <= data_p1;
            end
         end

         assign vld_out  = vld_p2;
         assign data_out = data_p2;
      end else begin : g_lat1
         assign vld_out  = vld_p1;
         assign data_out = data_p1;
      end
   endgenerate

endmodule

// File: rtl/dpram_tdp_sc.sv
// dpram_tdp_sc: single-clock true dual-port RAM with per-lane writes,
// selectable same-port read-during-write, clear engine and collision flag.
//   clk, rst                clock, asynchronous active-low reset
//   clr_req                 pulse; starts a clear pass when in RUN
//   ready                   1 = ports accept accesses
//   enX (active-low), wr_enX, lane_enX, addr_X, datain_X   port X request
//   dataout_X, rd_validX    port X read result and strobe
//   collision               pulse one cycle after a same-address access with a write
module dpram_tdp_sc
   import dpram_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int                    LANE_WIDTH   = LANE_WIDTH_DEF,
   parameter int                    RD_LATENCY   = 1,
   parameter int                    RDW_MODE     = 0,
   parameter int                    CLEAR_ON_RST = 1,
   parameter logic [DATA_WIDTH-1:0] CLR_VAL      = '0
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clr_req,
   output logic                             ready,
   input  logic                             enA,
   input  logic                             wr_enA,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] lane_enA,
   input  logic [ADDR_WIDTH-1:0]            addr_A,
   input  logic [DATA_WIDTH-1:0]            datain_A,
   output logic [DATA_WIDTH-1:0]            dataout_A,
   output logic                             rd_validA,
   input  logic                             enB,
   input  logic                             wr_enB,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] lane_enB,
   input  logic [ADDR_WIDTH-1:0]            addr_B,
   input  logic [DATA_WIDTH-1:0]            datain_B,
   output logic [DATA_WIDTH-1:0]            dataout_B,
   output logic                             rd_validB,
   output logic                             collision
);

   localparam int WORDS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt;

   logic                  acc_a, acc_b, we_a, we_b, same_addr;
   logic [DATA_WIDTH-1:0] bm_a, bm_b, old_a, old_b;
   logic [DATA_WIDTH-1:0] merged_a, merged_b, merged_ba;
   logic                  wen_a, wen_b;
   logic [ADDR_WIDTH-1:0] waddr_a;
   logic [DATA_WIDTH-1:0] wdata_a;
   logic                  vld_a_p0, vld_b_p0;
   logic [DATA_WIDTH-1:0] data_a_p0, data_b_p0;

   // Lane enables fanned out to one mask bit per data bit.
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
      assign bm_a[i] = lane_enA[i / LANE_WIDTH];
      assign bm_b[i] = lane_enB[i / LANE_WIDTH];
   end

   // Accesses only count while ready; during a clear they are dropped.
   assign acc_a     = ready && !enA;
   assign acc_b     = ready && !enB;
   assign we_a      = acc_a && wr_enA;
   assign we_b      = acc_b && wr_enB;
   assign same_addr = (addr_A == addr_B);

   // Array reads are pre-write, which gives cross-port read-first for free.
   assign old_a    = mem[addr_A];
   assign old_b    = mem[addr_B];
   assign merged_a = DATA_WIDTH'(merge_word(MERGE_W'(old_a), MERGE_W'(datain_A), MERGE_W'(bm_a)));
   assign merged_b = DATA_WIDTH'(merge_word(MERGE_W'(old_b), MERGE_W'(datain_B), MERGE_W'(bm_b)));
   // Write/write to one address: B's lanes first, A's lanes on top.
   assign merged_ba = DATA_WIDTH'(merge_word(MERGE_W'(merged_b), MERGE_W'(datain_A), MERGE_W'(bm_a)));

   // The clear engine borrows the port A write path.
   always_comb begin
      wen_a   = we_a;
      waddr_a = addr_A;
      wdata_a = (we_b && same_addr) ? merged_ba : merged_a;
      if (state == CLEAR) begin
         wen_a   = 1'b1;
         waddr_a = clr_cnt;
         wdata_a = CLR_VAL;
      end
   end

   // On a shared address port A carries the combined word, so B stands down.
   assign wen_b = we_b && !(we_a && same_addr);

   always_ff @(posedge clk) begin
      if (wen_a) mem[waddr_a] <= wdata_a;
      if (wen_b) mem[addr_B]  <= merged_b;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == '1) state_nxt = RUN;
         RUN:     if (clr_req)       state_nxt = CLEAR;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
         clr_cnt   <= '0;
         ready     <= 1'b0;
         collision <= 1'b0;
      end else begin
         state     <= state_nxt;
         ready     <= (state_nxt == RUN);
         // Counter wraps to 0 naturally after the last address.
         clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
         collision <= acc_a && acc_b && same_addr && (wr_enA || wr_enB);
      end
   end

   // Write-first returns this port's own merged word.
   assign vld_a_p0  = acc_a && (!wr_enA || (RDW_MODE == 1));
   assign vld_b_p0  = acc_b && (!wr_enB || (RDW_MODE == 1));
   assign data_a_p0 = (wr_enA && (RDW_MODE == 1)) ? merged_a : old_a;
   assign data_b_p0 = (wr_enB && (RDW_MODE == 1)) ? merged_b : old_b;

   dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
      .clk      (clk),
      .rst      (rst),
      .vld_p0   (vld_a_p0),
      .data_p0  (data_a_p0),
      .vld_out  (rd_validA),
      .data_out (dataout_A)
   );

   dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
      .clk      (clk),
      .rst      (rst),
      .vld_p0   (vld_b_p0),
      .data_p0  (data_b_p0),
      .vld_out  (rd_validB),
      .data_out (dataout_B)
   );

endmodule

// File: tb/tb_dpram_tdp_sc.sv
// tb_dpram_tdp_sc: directed bench for dpram_tdp_sc. Two instances share the
// same stimulus: u_dut0 (latency 1, read-first) and u_dut1 (latency 2,
// write-first), both 16-bit words with two 8-bit lanes.
module tb_dpram_tdp_sc;
   import dpram_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic        enA, wr_enA, enB, wr_enB;
   logic [1:0]  lane_enA, lane_enB;
   logic [4:0]  addr_A, addr_B;
   logic [15:0] datain_A, datain_B;

   logic        rdy0, vld_a0, vld_b0, col0;
   logic [15:0] dout_a0, dout_b0;
   logic        rdy1, vld_a1, vld_b1, col1;
   logic [15:0] dout_a1, dout_b1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dpram_tdp_sc #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_ON_RST(1), .CLR_VAL(16'h0000)) u_dut0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy0),
      .enA(enA), .wr_enA(wr_enA), .lane_enA(lane_enA), .addr_A(addr_A),
      .datain_A(datain_A), .dataout_A(dout_a0), .rd_validA(vld_a0),
      .enB(enB), .wr_enB(wr_enB), .lane_enB(lane_enB), .addr_B(addr_B),
      .datain_B(datain_B), .dataout_B(dout_b0), .rd_validB(vld_b0),
      .collision(col0));

   dpram_tdp_sc #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_LATENCY(2),
                  .RDW_MODE(1), .CLEAR_ON_RST(1), .CLR_VAL(16'h0000)) u_dut1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(rdy1),
      .enA(enA), .wr_enA(wr_enA), .lane_enA(lane_enA), .addr_A(addr_A),
      .datain_A(datain_A), .dataout_A(dout_a1), .rd_validA(vld_a1),
      .enB(enB), .wr_enB(wr_enB), .lane_enB(lane_enB), .addr_B(addr_B),
      .datain_B(datain_B), .dataout_B(dout_b1), .rd_validB(vld_b1),
      .collision(col1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enA = 1'b1; wr_enA = 1'b0; lane_enA = 2'b00; addr_A = '0; datain_A = '0;
      enB = 1'b1; wr_enB = 1'b0; lane_enB = 2'b00; addr_B = '0; datain_B = '0;
      clr_req = 1'b0;
   endtask

   task automatic port_a(input logic wr, input logic [4:0] a, input logic [15:0] d, input logic [1:0] le);
      enA = 1'b0; wr_enA = wr; addr_A = a; datain_A = d; lane_enA = le;
   endtask

   task automatic port_b(input logic wr, input logic [4:0] a, input logic [15:0] d, input logic [1:0] le);
      enB = 1'b0; wr_enB = wr; addr_B = a; datain_B = d; lane_enB = le;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      repeat (3) tick();

      // Reset state
      chk("rst_ready0", 32'(rdy0), 32'd0);
      chk("rst_ready1", 32'(rdy1), 32'd0);
      chk("rst_vld0",   32'({vld_a0, vld_b0, col0}), 32'd0);
      chk("rst_vld1",   32'({vld_a1, vld_b1, col1}), 32'd0);
      chk("rst_dout0",  32'({dout_a0, dout_b0}), 32'd0);
      chk("rst_dout1",  32'({dout_a1, dout_b1}), 32'd0);

      // Power-up clear: ready low for exactly DEPTH cycles
      rst = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         tick();
         chk($sformatf("clr_ready0_c%0d", i), 32'(rdy0), 32'(i == DEPTH));
         chk($sformatf("clr_ready1_c%0d", i), 32'(rdy1), 32'(i == DEPTH));
      end

      // Back-to-back reads of every address after the clear
      for (int i = 0; i < DEPTH; i++) begin
         port_a(1'b0, 5'(i), 16'h0, 2'b00);
         tick();
         chk($sformatf("rd0_vld_%0d", i), 32'(vld_a0), 32'd1);
         chk($sformatf("rd0_dat_%0d", i), 32'(dout_a0), 32'h0);
         chk($sformatf("rd1_vld_%0d", i), 32'(vld_a1), 32'(i > 0));
      end
      idle();
      tick();
      chk("rd1_last_vld", 32'(vld_a1), 32'd1);
      chk("rd1_last_dat", 32'(dout_a1), 32'h0);
      chk("rd0_idle_vld", 32'(vld_a0), 32'd0);

      // A writes 0xF0 at 0x15, B reads it next cycle
      port_a(1'b1, 5'h15, 16'h00F0, 2'b11);
      tick();
      idle();
      port_b(1'b0, 5'h15, 16'h0, 2'b00);
      tick();
      chk("t2_b0_vld", 32'(vld_b0), 32'd1);
      chk("t2_b0_dat", 32'(dout_b0), 32'h00F0);
      chk("t2_a0_wr_novld", 32'(vld_a0), 32'd0);
      chk("t2_b1_early", 32'(vld_b1), 32'd0);
      chk("t2_a1_wf_vld", 32'(vld_a1), 32'd1);
      chk("t2_a1_wf_dat", 32'(dout_a1), 32'h00F0);
      idle();
      tick();
      chk("t2_b1_vld", 32'(vld_b1), 32'd1);
      chk("t2_b1_dat", 32'(dout_b1), 32'h00F0);
      chk("t2_b0_drop", 32'(vld_b0), 32'd0);
      chk("t2_b0_hold", 32'(dout_b0), 32'h00F0);

      // Lane-masked write: 0xABCD then 0x1234 on lane 0 only
      port_a(1'b1, 5'h03, 16'hABCD, 2'b11);
      tick();
      port_a(1'b1, 5'h03, 16'h1234, 2'b01);
      tick();
      port_a(1'b0, 5'h03, 16'h0, 2'b00);
      tick();
      chk("t3_a0_vld", 32'(vld_a0), 32'd1);
      chk("t3_a0_dat", 32'(dout_a0), 32'hAB34);
      idle();
      tick();
      chk("t3_a1_dat", 32'(dout_a1), 32'hAB34);

      // Write/write collision at 0x0A: A wins
      port_a(1'b1, 5'h0A, 16'h0011, 2'b11);
      port_b(1'b1, 5'h0A, 16'h0022, 2'b11);
      tick();
      chk("t4_ww_col0", 32'(col0), 32'd1);
      chk("t4_ww_col1", 32'(col1), 32'd1);
      // Read/write collision: A reads old word while B writes 0x33
      port_a(1'b0, 5'h0A, 16'h0, 2'b00);
      port_b(1'b1, 5'h0A, 16'h0033, 2'b11);
      tick();
      chk("t4_rw_col0", 32'(col0), 32'd1);
      chk("t4_rw_a0_dat", 32'(dout_a0), 32'h0011);
      idle();
      tick();
      chk("t4_col_drop", 32'(col0), 32'd0);
      chk("t4_rw_a1_dat", 32'(dout_a1), 32'h0011);
      // Read/read on one address is not a collision
      port_a(1'b0, 5'h0A, 16'h0, 2'b00);
      port_b(1'b0, 5'h0A, 16'h0, 2'b00);
      tick();
      chk("t4_rr_col0", 32'(col0), 32'd0);
      chk("t4_rr_a0_dat", 32'(dout_a0), 32'h0033);
      chk("t4_rr_b0_dat", 32'(dout_b0), 32'h0033);
      idle();
      tick();
      chk("t4_rr_col1", 32'(col1), 32'd0);
      chk("t4_rr_b1_dat", 32'(dout_b1), 32'h0033);
      // Partial-lane collision: A lane 0 = 0x44, B both lanes = 0x5566 -> 0x5544
      port_a(1'b1, 5'h0B, 16'h0044, 2'b01);
      port_b(1'b1, 5'h0B, 16'h5566, 2'b11);
      tick();
      idle();
      port_b(1'b0, 5'h0B, 16'h0, 2'b00);
      tick();
      chk("t4_mrg_b0", 32'(dout_b0), 32'h5544);
      idle();
      tick();
      chk("t4_mrg_b1", 32'(dout_b1), 32'h5544);

      // Same-port read-during-write at addr 7: 0x55 over 0xAA
      port_a(1'b1, 5'h07, 16'h00AA, 2'b11);
      tick();
      port_a(1'b0, 5'h07, 16'h0, 2'b00);
      tick();
      chk("t5_pre_a0", 32'(dout_a0), 32'h00AA);
      port_a(1'b1, 5'h07, 16'h0055, 2'b11);
      tick();
      chk("t5_rf_vld0", 32'(vld_a0), 32'd0);
      chk("t5_rf_dat0", 32'(dout_a0), 32'h00AA);
      chk("t5_pre_a1", 32'(dout_a1), 32'h00AA);
      idle();
      tick();
      chk("t5_wf_vld1", 32'(vld_a1), 32'd1);
      chk("t5_wf_dat1", 32'(dout_a1), 32'h0055);
      port_a(1'b0, 5'h07, 16'h0, 2'b00);
      tick();
      chk("t5_post_a0", 32'(dout_a0), 32'h0055);
      idle();

      // clr_req in RUN with a simultaneous access, then reset mid-clear
      port_a(1'b1, 5'h05, 16'h5A5A, 2'b11);
      tick();
      port_a(1'b1, 5'h09, 16'h0077, 2'b11);
      clr_req = 1'b1;
      tick();
      chk("t6_ready0_drop", 32'(rdy0), 32'd0);
      chk("t6_ready1_drop", 32'(rdy1), 32'd0);
      idle();
      port_a(1'b0, 5'h05, 16'h0, 2'b00);
      tick();                                   // clear cycle 1
      chk("t6_clr_rd_drop0", 32'(vld_a0), 32'd0);
      chk("t6_req_acc_vld1", 32'(vld_a1), 32'd1);
      chk("t6_req_acc_dat1", 32'(dout_a1), 32'h0077);
      idle();
      repeat (9) tick();                        // clear cycles 2..10
      rst = 1'b0;
      #1;
      chk("t6_rst_ready", 32'({rdy0, rdy1}), 32'd0);
      chk("t6_rst_vld", 32'({vld_a0, vld_b0, vld_a1, vld_b1}), 32'd0);
      chk("t6_rst_col", 32'({col0, col1}), 32'd0);
      chk("t6_rst_dout0", 32'({dout_a0, dout_b0}), 32'd0);
      chk("t6_rst_dout1", 32'({dout_a1, dout_b1}), 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         if (i == 20) begin
            port_a(1'b1, 5'h02, 16'h00EE, 2'b11);
            port_b(1'b0, 5'h02, 16'h0, 2'b00);
         end else begin
            idle();
         end
         tick();
         chk($sformatf("t6_ready0_c%0d", i), 32'(rdy0), 32'(i == DEPTH));
         if (i == 20) chk("t6_drop_vld_b0", 32'(vld_b0), 32'd0);
      end
      port_a(1'b0, 5'h05, 16'h0, 2'b00);
      port_b(1'b0, 5'h02, 16'h0, 2'b00);
      tick();
      chk("t6_a0_vld", 32'(vld_a0), 32'd1);
      chk("t6_a0_clr", 32'(dout_a0), 32'h0);
      chk("t6_b0_vld", 32'(vld_b0), 32'd1);
      chk("t6_b0_drop", 32'(dout_b0), 32'h0);
      idle();
      tick();
      chk("t6_a1_clr", 32'(dout_a1), 32'h0);
      chk("t6_b1_drop", 32'(dout_b1), 32'h0);
      chk("t6_b1_vld", 32'(vld_b1), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
